// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order store buffer in front of a single-port data memory.
//
// Stores are queued in a DEPTH-entry FIFO. The head entry is written to memory
// whenever the memory port is free (no load this cycle). It is also written
// when the buffer is full or a flush is requested, because in those cases the
// drain takes the port away from the load. Loads probe the queued entries so
// that they never read stale memory.
//
// Optional feature macro: SB_FORWARD_EN
//   defined   : loads are satisfied from the youngest matching entry where
//               possible (ld_hit/ld_data). A WD load over a younger UB entry
//               must retry (ld_stall).
//   undefined : no forwarding. A load whose word matches any queued entry
//               retries (ld_stall) until that entry has drained.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   st_valid/st_ready       store handshake; st_op/st_addr/st_data payload
//   ld_en/ld_op/ld_addr     load using the memory port this cycle
//   ld_hit/ld_stall/ld_data forward result / retry request / forwarded data
//   flush                   drain everything, refuse new stores
//   dm_en/dm_we/dm_op/dm_addr/dm_data  data-memory write port
//   empty, count            occupancy

`ifndef DM_ADDR_BIT
  `define DM_ADDR_BIT 32
`endif
`ifndef DM_OP_BIT
  `define DM_OP_BIT 2
`endif
`ifndef DM_OP_WD
  `define DM_OP_WD 2'd2
`endif
`ifndef DM_OP_UB
  `define DM_OP_UB 2'd0
`endif

module dm_store_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_BIT = `DM_ADDR_BIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [`DM_OP_BIT-1:0]   st_op,
  input  logic [ADDR_BIT-1:0]     st_addr,
  input  logic [31:0]             st_data,
  input  logic                    ld_en,
  input  logic [`DM_OP_BIT-1:0]   ld_op,
  input  logic [ADDR_BIT-1:0]     ld_addr,
  output logic                    ld_hit,
  output logic                    ld_stall,
  output logic [31:0]             ld_data,
  input  logic                    flush,
  output logic                    dm_en,
  output logic                    dm_we,
  output logic [`DM_OP_BIT-1:0]   dm_op,
  output logic [ADDR_BIT-1:0]     dm_addr,
  output logic [31:0]             dm_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]          valid;
  logic [`DM_OP_BIT-1:0]     op_q   [DEPTH];
  logic [ADDR_BIT-1:0]       addr_q [DEPTH];
  logic [31:0]               data_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count_q;

  logic full;
  logic push;
  logic drain;
  logic override;
  logic match_any;
  logic [PTR_W-1:0] idx;
`ifdef SB_FORWARD_EN
  logic        fwd_hit;
  logic        fwd_stall;
  logic [31:0] fwd_data;
`endif

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = rst_n && !full && !flush;
  assign push     = st_valid && st_ready;
  // Drain whenever the port is free, or forcibly when full/flushing.
  assign drain    = rst_n && !empty && (!ld_en || full || flush);
  assign override = ld_en && drain;

  assign dm_en   = drain;
  assign dm_we   = drain;
  assign dm_op   = drain ? op_q[rd_ptr]   : ld_op;
  assign dm_addr = drain ? addr_q[rd_ptr] : ld_addr;
  assign dm_data = drain ? data_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      // A push never targets the slot being drained: push needs !full, so
      // wr_ptr == rd_ptr only when empty, and then nothing drains.
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_q[wr_ptr]   <= st_op;
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    match_any = 1'b0;
    idx       = '0;
`ifdef SB_FORWARD_EN
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && (addr_q[idx][ADDR_BIT-1:2] == ld_addr[ADDR_BIT-1:2])) begin
        match_any = 1'b1;
`ifdef SB_FORWARD_EN
        if (ld_op == `DM_OP_UB) begin
          // A UB entry only covers its own byte; other bytes leave older
          // covering entries in effect.
          if (op_q[idx] == `DM_OP_WD) begin
            fwd_hit  = 1'b1;
            fwd_data = {24'h0, data_q[idx][{ld_addr[1:0], 3'b000} +: 8]};
          end else if (addr_q[idx][1:0] == ld_addr[1:0]) begin
            fwd_hit  = 1'b1;
            fwd_data = {24'h0, data_q[idx][7:0]};
          end
        end else begin
          fwd_hit   = (op_q[idx] == `DM_OP_WD);
          fwd_stall = (op_q[idx] != `DM_OP_WD);
          fwd_data  = (op_q[idx] == `DM_OP_WD) ? data_q[idx] : '0;
        end
`endif
      end
    end
  end

  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (rst_n && ld_en) begin
      if (override) begin
        ld_stall = 1'b1;
      end else begin
`ifdef SB_FORWARD_EN
        ld_hit   = fwd_hit;
        ld_stall = fwd_stall;
        ld_data  = fwd_data;
`else
        ld_stall = match_any;
`endif
      end
    end
  end

endmodule
